// File: rtl/icache_loader_pkg.sv
// Shared icache types: cache geometry, word/index typedefs and the fill-loader state encoding
// that core-side stall/debug logic decodes.
package icache_loader_pkg;

   localparam int ICACHE_DEPTH = 32;
   localparam int ICACHE_IW    = $clog2(ICACHE_DEPTH);

   typedef logic [ICACHE_IW-1:0] address;
   typedef logic [31:0]          instruction;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } loader_state_t;

endpackage

// File: rtl/icache_loader_if.sv
// Bundle of the loader's control, memory-read handshake and icache write-port signals.
// The loader owns the master side; memory, icache and the core sit on the slave side.
interface icache_loader_if
   import icache_loader_pkg::*;
#(
   parameter int DEPTH = ICACHE_DEPTH
) ();

   localparam int IW = $clog2(DEPTH);

   logic          start;
   logic [31:0]   base_addr;
   logic [IW:0]   count;

   logic          mem_req;
   logic [31:0]   mem_addr;
   logic          mem_ack;
   instruction    mem_rdata;

   logic          ic_write;
   address        ic_write_addr;
   instruction    ic_write_data;

   logic          busy;
   logic          done;
   logic          err;

   modport master (
      input  start, base_addr, count, mem_ack, mem_rdata,
      output mem_req, mem_addr, ic_write, ic_write_addr, ic_write_data, busy, done, err
   );

   modport slave (
      output start, base_addr, count, mem_ack, mem_rdata,
      input  mem_req, mem_addr, ic_write, ic_write_addr, ic_write_data, busy, done, err
   );

endinterface

// File: rtl/icache_loader_timer.sv
// Per-word wait timer: clearable up-counter whose flag marks the TIMEOUT-th enabled cycle.
// It stops at that value so the flag stays high until the owner clears it.
module loader_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expired) begin
         cnt_d = cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/icache_loader.sv
// Instruction-cache fill controller: copies a block of memory words into consecutive icache
// entries over a req/ack handshake while holding the core stalled via busy.
module icache_loader
   import icache_loader_pkg::*;
#(
   parameter int DEPTH   = ICACHE_DEPTH,
   parameter int TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           rst,
   icache_loader_if.master bus
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [IW:0] DEPTH_CNT = (IW + 1)'(DEPTH);
   localparam logic [IW:0] IDX_ONE   = (IW + 1)'(1);

   loader_state_t state_q, state_d;
   logic [31:0]   base_q, base_d;
   logic [IW:0]   count_q, count_d;
   logic [IW:0]   idx_q, idx_d;
   logic          mem_req_q, mem_req_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic          ic_write_q, ic_write_d;
   address        ic_write_addr_q, ic_write_addr_d;
   instruction    ic_write_data_q, ic_write_data_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic          tmr_clr;
   logic          tmr_en;
   logic          tmr_expired;
   logic [IW:0]   start_count;
   logic [IW:0]   idx_next;
   logic [IW:0]   idx_last;

   // The timer only runs while a request is outstanding; any other state rearms it.
   assign tmr_en  = (state_q == REQ);
   assign tmr_clr = (state_q != REQ);

   loader_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   assign start_count = (bus.count > DEPTH_CNT) ? DEPTH_CNT : bus.count;
   assign idx_next    = idx_q + IDX_ONE;
   assign idx_last    = count_q - IDX_ONE;

   // Outputs are registered: each is computed here from the state being entered.
   always_comb begin
      state_d         = state_q;
      base_d          = base_q;
      count_d         = count_q;
      idx_d           = idx_q;
      mem_req_d       = mem_req_q;
      mem_addr_d      = mem_addr_q;
      ic_write_d      = 1'b0;
      ic_write_addr_d = ic_write_addr_q;
      ic_write_data_d = ic_write_data_q;
      busy_d          = busy_q;
      done_d          = 1'b0;
      err_d           = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (start_count == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d    = REQ;
                  base_d     = bus.base_addr;
                  count_d    = start_count;
                  idx_d      = '0;
                  mem_req_d  = 1'b1;
                  mem_addr_d = bus.base_addr;
                  busy_d     = 1'b1;
               end
            end
         end
         REQ: begin
            // An ack in the cycle the timer expires still completes the word.
            if (bus.mem_ack) begin
               state_d         = WRITE;
               mem_req_d       = 1'b0;
               ic_write_d      = 1'b1;
               ic_write_addr_d = idx_q[IW-1:0];
               ic_write_data_d = bus.mem_rdata;
            end else if (tmr_expired) begin
               state_d   = ERR;
               mem_req_d = 1'b0;
               busy_d    = 1'b0;
               err_d     = 1'b1;
            end
         end
         WRITE: begin
            if (idx_q == idx_last) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d    = REQ;
               idx_d      = idx_next;
               mem_req_d  = 1'b1;
               mem_addr_d = base_q + 32'(idx_next);
            end
         end
         DONE, ERR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         base_q          <= '0;
         count_q         <= '0;
         idx_q           <= '0;
         mem_req_q       <= 1'b0;
         mem_addr_q      <= '0;
         ic_write_q      <= 1'b0;
         ic_write_addr_q <= '0;
         ic_write_data_q <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         base_q          <= base_d;
         count_q         <= count_d;
         idx_q           <= idx_d;
         mem_req_q       <= mem_req_d;
         mem_addr_q      <= mem_addr_d;
         ic_write_q      <= ic_write_d;
         ic_write_addr_q <= ic_write_addr_d;
         ic_write_data_q <= ic_write_data_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         err_q           <= err_d;
      end
   end

   assign bus.mem_req       = mem_req_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.ic_write      = ic_write_q;
   assign bus.ic_write_addr = ic_write_addr_q;
   assign bus.ic_write_data = ic_write_data_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.err           = err_q;

   // Structural invariants of the handshake and the completion pulses.
   a_req_addr_stable: assert property (@(posedge clk) disable iff (rst)
      (state_q == REQ && !bus.mem_ack && !tmr_expired) |=> (state_q == REQ && $stable(mem_addr_q)));
   a_write_single: assert property (@(posedge clk) disable iff (rst)
      ic_write_q |=> !ic_write_q);
   a_pulse_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(done_q && err_q) && !(busy_q && (done_q || err_q)));
   a_idx_in_range: assert property (@(posedge clk) disable iff (rst)
      busy_q |-> (idx_q < count_q));

endmodule

// File: doc/icache_loader.md
# icache_loader

Fill controller that sequences the instruction cache's write port. On a start pulse it fetches a contiguous block of instruction words from external memory over a req/ack handshake and writes each word into the icache at consecutive indices, holding the core stalled until the block is loaded. It sits between the memory interface and the icache write port (`write`, `write_addr`, `write_data`). The core's read port is untouched.

## Interface
Parameters:
- `DEPTH`, default 32: icache entries; index width `IW = $clog2(DEPTH)`.
- `TIMEOUT`, default 64: max cycles to wait for `mem_ack` per word; must be ≥ 1.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a load; sampled only in IDLE.
- `base_addr` in 32: memory word address of first instruction; sampled with `start`.
- `count` in IW+1: words to load, 0..DEPTH; sampled with `start`.
- `mem_req` out 1: memory read request.
- `mem_addr` out 32: word address for current request.
- `mem_ack` in 1: memory response; `mem_rdata` valid in the same cycle.
- `mem_rdata` in 32: instruction word.
- `ic_write` out 1: icache write enable.
- `ic_write_addr` out `address`: icache index.
- `ic_write_data` out `instruction`: word to write.
- `busy` out 1: load in progress; drives core stall.
- `done` out 1: one-cycle pulse, load completed.
- `err` out 1: one-cycle pulse, load aborted on timeout.

## Operation
- States: IDLE, REQ, WRITE, DONE, ERR.
- IDLE: `start`=1 with `count`≠0 → latch base/count, index←0, → REQ. `start`=1 with `count`=0 → DONE directly; nothing is written.
- REQ: `mem_req`=1, `mem_addr`=base+index, held stable until ack. `mem_ack`=1 → capture `mem_rdata`, → WRITE. Timer counts cycles in REQ. Reaching TIMEOUT without an ack → ERR.
- WRITE: `ic_write`=1 for exactly one cycle with `ic_write_addr`=index[IW-1:0] and the captured data. If index = count−1 → DONE. Otherwise index+1 → REQ, and the timer clears.
- DONE: `done`=1 for one cycle → IDLE.
- ERR: `err`=1 for one cycle, `mem_req`=0 → IDLE. Words already written stay in the cache.
- `busy`=1 in REQ and WRITE; 0 in IDLE, DONE and ERR.
- Arithmetic: `mem_addr` = base+index modulo 2^32, so it wraps at the top of the address space. Index is IW+1 bits wide. `count`>DEPTH is clamped to DEPTH.
- `start` outside IDLE is ignored; it is not queued.
- `mem_ack` outside REQ is ignored.

## Timing
- Reset (`rst`=1 at an edge), in any state: next cycle is IDLE. `mem_req`, `ic_write`, `busy`, `done` and `err` are 0; `mem_addr`, `ic_write_addr` and `ic_write_data` are 0; timer and index are 0. A load interrupted by reset performs no further writes and does not pulse `done` or `err`.
- `start` at edge t → `mem_req`=1 and `busy`=1 from cycle t+1.
- Ack at cycle a → `ic_write` in cycle a+1 → next `mem_req` in cycle a+2, or `done` in a+2 on the last word.
- Zero-wait memory (ack in the first REQ cycle): 2 cycles/word. N words: `done` at t+1+2N.
- `count`=0: `done` at t+1; `busy` never asserts.
- Timeout: ack absent for TIMEOUT consecutive REQ cycles → `err` in the next cycle. An ack arriving in the same cycle the timer expires wins.

## Structure
- `address` and `instruction` typedefs and `ICACHE_DEPTH` come from the shared types header. No local redefinition.
- The state enum `loader_state_t` goes in the shared types header so the core-side stall/debug logic can decode it.
- One sub-module: `loader_timer`, a clearable up-counter with terminal-count flag, parameter TIMEOUT. Everything else is a single always_comb next-state block and a single always_ff register block.

## Test plan
- base=0x100, count=4, ack on first REQ cycle each time → writes idx 0..3 with rdata of 0x100..0x103; `done` at t+9; `busy` high cycles t+1..t+8.
- count=3, ack delayed 5 cycles per word (TIMEOUT=64) → `mem_addr` stable through each wait; 3 writes; `done` at t+1+3·7 = t+22.
- TIMEOUT=4, count=2, ack word 0, never ack word 1 → one write at idx 0; `err` pulse 4 REQ cycles later; `done` never asserts; back to IDLE.
- base=0xFFFF_FFFF, count=2 → `mem_addr` 0xFFFF_FFFF then 0x0000_0000; writes idx 0,1.
- count=0 → `done` at t+1, no `mem_req`/`ic_write`. Then `start` with count=32 → all 32 indices written exactly once.
- `rst` asserted in the WRITE of word 2 of 5 → next cycle all outputs 0, state IDLE. Later `start` restarts cleanly from idx 0; a second `start` while busy is ignored.
